// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard sequencer.
//   pipe_state_e   : sequencer FSM state (RUN, MD_BUSY)
//   MEM_TO_DEFAULT : default MEM-wait watchdog limit in cycles (0 disables)
//   WAIT_W, CNT_W  : watchdog counter and performance counter widths
package pipe_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } pipe_state_e;

    localparam int unsigned MEM_TO_DEFAULT = 255;
    localparam int unsigned WAIT_W         = 8;
    localparam int unsigned CNT_W          = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard requests from the pipeline and the resulting
// stall/flush controls, timeout pulse and performance counters.
//   master : pipeline side (drives requests, receives controls)
//   slave  : hazard sequencer side
interface pipe_hazard_ctrl_if;
    import pipe_pkg::*;

    logic             lu_stall;
    logic             ex_redirect;
    logic             md_start;
    logic             md_done;
    logic             dmem_req;
    logic             dmem_ack;
    logic             pc_stall;
    logic             ifid_stall;
    logic             idex_stall;
    logic             exmem_stall;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output lu_stall, ex_redirect, md_start, md_done, dmem_req, dmem_ack,
        input  pc_stall, ifid_stall, idex_stall, exmem_stall,
        input  ifid_flush, idex_flush, exmem_flush, memwb_flush,
        input  mem_timeout, stall_cnt, redirect_cnt
    );

    modport slave (
        input  lu_stall, ex_redirect, md_start, md_done, dmem_req, dmem_ack,
        output pc_stall, ifid_stall, idex_stall, exmem_stall,
        output ifid_flush, idex_flush, exmem_flush, memwb_flush,
        output mem_timeout, stall_cnt, redirect_cnt
    );

endinterface

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: free-running stall and redirect cycle counters, wrapping
// modulo 2^CNT_W.
//   clk, rst_n    : clock, async active-low reset
//   stall_inc     : count one stall cycle
//   redirect_inc  : count one redirect cycle
//   stall_cnt, redirect_cnt : counter values
module pipe_perf_cnt
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_inc,
    input  logic             redirect_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    // Next counter values
    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (stall_inc)    stall_cnt_d    = stall_cnt_q + CNT_W'(1);
        if (redirect_inc) redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: resolves load-use, redirect, mul/div and data-memory
// hazards by stage priority (MEM hold > MD hold > redirect > load-use) into
// per-register stall and flush controls, with a MEM-wait watchdog.
//   clk, rst_n : clock, async active-low reset
//   bus        : pipe_hazard_ctrl_if.slave (requests in, controls out)
//   MEM_TO     : watchdog limit in cycles, 0 disables
// Optional feature macro: PIPE_HAZARD_PERF_EN builds the performance
// counters; otherwise stall_cnt/redirect_cnt are tied to zero.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MEM_TO = MEM_TO_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam bit          TO_EN   = (MEM_TO != 0);
    localparam int unsigned TO_LAST = TO_EN ? MEM_TO - 1 : 0;

    pipe_state_e       state_q, state_d;
    logic              done_q, done_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic mem_hold, md_hold, timeout;
    logic pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

    assign mem_hold = bus.dmem_req & ~bus.dmem_ack;
    // A result already latched in done_q releases MD_BUSY without a new md_done
    assign md_hold  = ((state_q == RUN) & bus.md_start & ~bus.md_done)
                    | ((state_q == MD_BUSY) & ~bus.md_done & ~done_q);
    assign timeout  = mem_hold & TO_EN & (wait_cnt_q == WAIT_W'(TO_LAST));

    // Stall/flush resolution; only the highest-priority source acts
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (timeout) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (mem_hold) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
        end else if (md_hold) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_flush = 1'b1;
        end else if (bus.ex_redirect) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (bus.lu_stall) begin
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_flush  = 1'b1;
        end
    end

    // FSM, latched md_done and watchdog next state
    always_comb begin
        state_d    = state_q;
        done_d     = done_q;
        wait_cnt_d = mem_hold ? wait_cnt_q + WAIT_W'(1) : '0;
        if (timeout) begin
            state_d    = RUN;
            done_d     = 1'b0;
            wait_cnt_d = '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (bus.md_start & ~bus.md_done & ~mem_hold) state_d = MD_BUSY;
                end
                MD_BUSY: begin
                    if (mem_hold) begin
                        if (bus.md_done) done_d = 1'b1;
                    end else if (bus.md_done | done_q) begin
                        state_d = RUN;
                        done_d  = 1'b0;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            done_q     <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign bus.pc_stall    = pc_stall;
    assign bus.ifid_stall  = ifid_stall;
    assign bus.idex_stall  = idex_stall;
    assign bus.exmem_stall = exmem_stall;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_flush = memwb_flush;
    assign bus.mem_timeout = rst_n & timeout;

`ifdef PIPE_HAZARD_PERF_EN
    // ifid_flush outside reset comes only from a redirect or a timeout
    pipe_perf_cnt u_perf_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_inc    (pc_stall),
        .redirect_inc (ifid_flush & rst_n),
        .stall_cnt    (bus.stall_cnt),
        .redirect_cnt (bus.redirect_cnt)
    );
`else
    assign bus.stall_cnt    = '0;
    assign bus.redirect_cnt = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage integer pipeline. It takes the load-use stall request from ID, the control-flow redirect from EX, the multi-cycle mul/div handshake in EX, and the data-memory handshake in MEM. It resolves them by stage priority into per-register stall (hold) and flush (bubble) controls, and tracks multi-cycle EX operations and MEM wait states with a small FSM and a watchdog counter.

## Interface
- MEM_TO, 255: MEM-wait watchdog limit in cycles; 0 disables the watchdog.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- lu_stall  in  1  load-use hazard detected on the instruction in ID
- ex_redirect  in  1  taken branch/jump resolved in EX
- md_start  in  1  a mul/div is entering operation in EX this cycle
- md_done  in  1  mul/div result valid (single-cycle pulse)
- dmem_req  in  1  MEM stage has an outstanding data access
- dmem_ack  in  1  data memory completes the access this cycle
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold PC / pipeline register
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load bubble into register
- mem_timeout  out  1  one-cycle pulse on watchdog expiry, to trap logic
- stall_cnt, redirect_cnt  out  32 each  performance counters (see Configuration)

## Operation
- FSM states: RUN, MD_BUSY. Side state: done_q (latched md_done), wait_cnt.
- MEM hold = dmem_req & ~dmem_ack. Sets pc/ifid/idex/exmem_stall=1 and memwb_flush=1. All other stalls and flushes are suppressed.
- MD hold = (RUN & md_start & ~md_done) | (MD_BUSY & ~md_done & ~done_q). Sets pc/ifid/idex_stall=1 and exmem_flush=1.
- Redirect sets ifid_flush=1 and idex_flush=1, with no stall.
- Load-use sets pc/ifid_stall=1 and idex_flush=1.
- Priority: MEM hold > MD hold > redirect > load-use. A suppressed redirect or load-use is not stored; the source stage is held, so the request re-presents itself.
- Transitions:
  - RUN->MD_BUSY on md_start & ~md_done & ~MEM hold. md_start is ignored during MEM hold.
  - MD_BUSY->RUN on (md_done | done_q) & ~MEM hold, and done_q clears.
  - md_done arriving during MEM hold sets done_q.
- Watchdog: wait_cnt increments on each consecutive MEM hold cycle and clears otherwise.
  - When MEM hold is active and wait_cnt==MEM_TO-1: mem_timeout=1; all four flushes=1 and all stalls=0 that cycle.
  - Next state is RUN, done_q and wait_cnt clear.
- While rst_n=0: all stalls 0, all flushes 1, mem_timeout 0, FSM=RUN, done_q=0, wait_cnt=0, counters 0.

## Timing
- Stall and flush outputs are combinational from inputs and registered state: zero-cycle latency.
- The release cycle, when md_done or dmem_ack is high, has no stall from that source.
- A single-cycle mul/div (md_start & md_done in the same cycle) produces no stall.
- dmem_ack with dmem_req low is ignored.
- On reset deassertion, the first clk edge sees RUN with idle outputs.

## Configuration
- PIPE_HAZARD_PERF_EN defined:
  - stall_cnt increments every cycle pc_stall=1.
  - redirect_cnt increments every cycle a redirect takes effect, i.e. ifid_flush from redirect or timeout.
  - Both wrap modulo 2^32.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- pipe_pkg holds the FSM state enum (RUN, MD_BUSY) and the default MEM_TO constant.
- One sub-module, pipe_perf_cnt: the two 32-bit counters, instantiated only under PIPE_HAZARD_PERF_EN.

## Test plan
- Reset: hold rst_n=0 with dmem_req=1 -> stalls 0, all flushes 1. Release with inputs idle -> all outputs 0.
- Load-use: lu_stall=1 for 1 cycle -> pc/ifid_stall=1, idex_flush=1. Add ex_redirect in the same cycle -> stalls 0, ifid/idex_flush=1.
- Mul/div: md_start at cycle 0, md_done at cycle 5 -> pc/ifid/idex_stall and exmem_flush high in cycles 0-4, all low in cycle 5.
- Overlap: MD_BUSY, dmem_req high cycles 2-6, md_done at cycle 4, ack at cycle 6 -> exmem_stall and memwb_flush in cycles 2-5, done_q set. Cycle 6: no stall and FSM returns to RUN.
- Watchdog with MEM_TO=4: dmem_req held, never acked -> stalls in cycles 0-2. Cycle 3: mem_timeout=1, all four flushes=1. Cycle 4: wait_cnt restarts.
- Perf (PIPE_HAZARD_PERF_EN): 7 stall cycles plus 2 redirects -> stall_cnt=7, redirect_cnt=2. Preload-free wrap check: force stall_cnt to 0xFFFFFFFF, one more stall -> 0.
